dsc_mul_seq: RTL and testbench

//  Sequencer for an NxN deterministic stochastic-computing (DSC) multiply.
//  - Latches two unsigned binary operands on a start handshake.
//  - Generates clock-division unary bitstreams internally and ANDs them.
//  - Counts the ones to produce the exact product z = a*b.
//  - Reports done and the run-cycle count.
//  - z must match the combinational array_mul for the same a and b.
//    The bench uses array_mul as the golden model.

---
 rtl/dsc_mul_seq.sv | 141 ++++++++++++++
 tb/tb_dsc_mul_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: sequencer for an NxN deterministic stochastic-computing multiply.
// A start handshake latches the two operands. Two clock-division counters then
// generate unary bitstreams. The bitstreams are ANDed and their ones are counted,
// which gives the exact product z = a*b. The block also reports the run length.
// Optional build macro: DSC_MUL_EARLY_TERM_EN. When it is defined, the run stops
// as soon as no later row can contribute to the product.
module dsc_mul_seq #(
  parameter int NUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_BITS-1:0]   a_in,
  input  logic [NUM_BITS-1:0]   b_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [2*NUM_BITS-1:0] z,
  output logic [2*NUM_BITS:0]   cycles
);

  localparam logic [NUM_BITS-1:0] CTR_MAX = {NUM_BITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_BITS-1:0]   a_reg_q, a_reg_d;
  logic [NUM_BITS-1:0]   b_reg_q, b_reg_d;
  logic [NUM_BITS-1:0]   ctr_a_q, ctr_a_d;
  logic [NUM_BITS-1:0]   ctr_b_q, ctr_b_d;
  logic [2*NUM_BITS-1:0] acc_q, acc_d;
  logic [2*NUM_BITS:0]   cyc_q, cyc_d;
  logic [2*NUM_BITS-1:0] z_q, z_d;
  logic [2*NUM_BITS:0]   cycles_q, cycles_d;

  logic sn;
  logic last_col;
  logic last_row;

  // Next-state, datapath update and end-of-run detection.
  always_comb begin
    // NOTE: every variable is given a hold default first, so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    ctr_a_d  = ctr_a_q;
    ctr_b_d  = ctr_b_q;
    acc_d    = acc_q;
    cyc_d    = cyc_q;
    z_d      = z_q;
    cycles_d = cycles_q;

    // A's stream is the fast column counter. B's stream is the slow row counter.
    sn       = (a_reg_q > ctr_a_q) && (b_reg_q > ctr_b_q);
    last_col = (ctr_a_q == CTR_MAX);
`ifdef DSC_MUL_EARLY_TERM_EN
    // Rows with ctr_b >= b_reg add nothing, so the run stops after row b_reg-1.
    last_row = (ctr_b_q == (b_reg_q - NUM_BITS'(1)));
`else
    last_row = (ctr_b_q == CTR_MAX);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_reg_d = a_in;
          b_reg_d = b_in;
          ctr_a_d = '0;
          ctr_b_d = '0;
          acc_d   = '0;
          cyc_d   = '0;
          state_d = S_RUN;
`ifdef DSC_MUL_EARLY_TERM_EN
          if ((a_in == '0) || (b_in == '0)) begin
            z_d      = '0;
            cycles_d = '0;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        acc_d   = acc_q + {{(2*NUM_BITS-1){1'b0}}, sn};
        cyc_d   = cyc_q + 1'b1;
        ctr_a_d = ctr_a_q + 1'b1;
        if (last_col) begin
          ctr_b_d = ctr_b_q + 1'b1;
        end
        // Results are loaded on the last RUN edge, so they are valid while done is high.
        if (last_col && last_row) begin
          z_d      = acc_d;
          cycles_d = cyc_d;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears them and aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      ctr_a_q  <= '0;
      ctr_b_q  <= '0;
      acc_q    <= '0;
      cyc_q    <= '0;
      z_q      <= '0;
      cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from their pre-edge values.
      state_q  <= state_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      ctr_a_q  <= ctr_a_d;
      ctr_b_q  <= ctr_b_d;
      acc_q    <= acc_d;
      cyc_q    <= cyc_d;
      z_q      <= z_d;
      cycles_q <= cycles_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign z      = z_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: randomized self-checking bench for dsc_mul_seq.
// The expected values come from a shift-and-add array multiplier and from the
// run-length rules. The run length depends on DSC_MUL_EARLY_TERM_EN.
module tb_dsc_mul_seq;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] z;
  logic [2*N:0]   cycles;

  int total;
  int bad;

  dsc_mul_seq #(.NUM_BITS(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .z      (z),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden combinational array multiplier: sum of shifted partial products.
  function automatic int array_mul(input int a, input int b);
    int acc;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

  // Expected run length of one operation.
  function automatic int exp_cycles(input int a, input int b);
`ifdef DSC_MUL_EARLY_TERM_EN
    if (a == 0 || b == 0) return 0;
    return b * (1 << N);
`else
    return 1 << (2 * N);
`endif
  endfunction

  // Runs one operation from IDLE. It returns z and cycles as seen in the done
  // cycle. lat counts edges from the accepting edge (inclusive) to done.
  // post_ok is 1 when the cycle after done is IDLE with done low.
  task automatic do_op(input int a, input int b,
                       output int oz, output int ocyc, output int lat,
                       output bit seen, output bit post_ok);
    @(negedge clk);
    a_in  = N'(a);
    b_in  = N'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = N'($urandom);
    b_in  = N'($urandom);
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = done;
    oz   = int'(z);
    ocyc = int'(cycles);
    @(posedge clk); #1;
    post_ok = ready && !done;
  endtask

  // Runs one operation and compares every observed value with the model.
  task automatic op_and_check(input string name, input int a, input int b);
    int oz, ocyc, lat;
    bit seen, post_ok;
    do_op(a, b, oz, ocyc, lat, seen, post_ok);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d edges (a=%0d b=%0d)", name, lat, a, b);
    end
    total++;
    if (oz !== array_mul(a, b)) begin
      bad++;
      $display("FAIL %s z: got %0d expected %0d (a=%0d b=%0d)", name, oz, array_mul(a, b), a, b);
    end
    total++;
    if (ocyc !== exp_cycles(a, b)) begin
      bad++;
      $display("FAIL %s cycles: got %0d expected %0d", name, ocyc, exp_cycles(a, b));
    end
    total++;
    if (lat !== exp_cycles(a, b) + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_cycles(a, b) + 1);
    end
    total++;
    if (!post_ok) begin
      bad++;
      $display("FAIL %s post-done: ready=%0b done=%0b expected ready=1 done=0", name, ready, done);
    end
  endtask

  task automatic test_reset();
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || z !== '0 || cycles !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%0b busy=%0b done=%0b z=%0d cycles=%0d expected 1 0 0 0 0",
               ready, busy, done, z, cycles);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    @(negedge clk);
    a_in = 4'd12; b_in = 4'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_busy: got %0b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || z !== '0 || cycles !== '0) begin
      bad++;
      $display("FAIL mid_run_reset: ready=%0b busy=%0b done=%0b z=%0d cycles=%0d expected 1 0 0 0 0",
               ready, busy, done, z, cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_no_done: dones=%0d ready=%0b expected 0 and 1", dones, ready);
    end
    op_and_check("restart_12x11", 12, 11);
  endtask

  task automatic test_boundaries();
    op_and_check("max_15x15", 15, 15);
    op_and_check("zero_0x9", 0, 9);
    op_and_check("zero_7x0", 7, 0);
  endtask

  task automatic test_ignore_start();
    int dones, budget, zdone;
    @(negedge clk);
    a_in = 4'd5; b_in = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    a_in = 4'd3; b_in = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; zdone = -1; budget = 0;
    while (!(ready && dones > 0) && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      if (done) begin dones++; zdone = int'(z); end
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignore_start dones: got %0d expected 1", dones);
    end
    total++;
    if (zdone !== array_mul(5, 7)) begin
      bad++;
      $display("FAIL ignore_start z: got %0d expected %0d", zdone, array_mul(5, 7));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a_in = 4'd2; b_in = 4'd3; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!done && lat < 400);
      total++;
      if (!done || z !== 8'(array_mul(2, 3)) || cycles !== 9'(exp_cycles(2, 3))) begin
        bad++;
        $display("FAIL back_to_back op%0d: done=%0b z=%0d cycles=%0d expected 1 %0d %0d",
                 k, done, z, cycles, array_mul(2, 3), exp_cycles(2, 3));
      end
      @(posedge clk); #1;
      if (k == 2) start = 1'b0;
      total++;
      if (ready !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back ready%0d: got %0b expected 1", k, ready);
      end
    end
    @(posedge clk); #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back idle: ready=%0b expected 1", ready);
    end
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      op_and_check("random", a, b);
      total++;
      if ($isunknown({ready, busy, done, z, cycles})) begin
        bad++;
        $display("FAIL random_x: outputs=%b expected no X", {ready, busy, done, z, cycles});
      end
      total++;
      if (array_mul(a, b) !== a * b) begin
        bad++;
        $display("FAIL random_golden: array_mul=%0d a*b=%0d", array_mul(a, b), a * b);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset_mid_run();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
